// File: rtl/ota_dec_pkg.sv
// Shared constants and width helper for the OTA comparator decimator.
// cnt_w is also used by the top-level readback mux.
package ota_dec_pkg;

    localparam int WIN_LOG2_DEF    = 8;
    localparam int SYNC_STAGES_DEF = 2;

    // A count must hold 0..2^win_log2 inclusive, so one bit more than the phase.
    function automatic int cnt_w(input int win_log2);
        return win_log2 + 1;
    endfunction

endpackage

// File: rtl/ota_sync_ff.sv
// Multi-flop synchronizer; the only point where cmp_in enters the clk domain.
module ota_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/ota_cmp_decimator.sv
// Counts ones and toggles of the synchronized comparator output over fixed
// windows of 2^WIN_LOG2 clocks and presents each result with valid/ack.
module ota_cmp_decimator
    import ota_dec_pkg::*;
#(
    parameter  int WIN_LOG2    = WIN_LOG2_DEF,
    parameter  int SYNC_STAGES = SYNC_STAGES_DEF,
    localparam int CNT_W       = cnt_w(WIN_LOG2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cmp_in,
    input  logic             ack,
    output logic [CNT_W-1:0] ones_cnt,
    output logic [CNT_W-1:0] tog_cnt,
    output logic             valid,
    output logic             overrun,
    output logic             busy
);

    logic                sample;
    logic                prev_q;
    logic [WIN_LOG2-1:0] phase_q, phase_d;
    logic [CNT_W-1:0]    acc_ones_q, acc_ones_d;
    logic [CNT_W-1:0]    acc_tog_q, acc_tog_d;
    logic [CNT_W-1:0]    ones_q, ones_d;
    logic [CNT_W-1:0]    tog_q, tog_d;
    logic                valid_q, valid_d;
    logic                overrun_q, overrun_d;
    logic                term;
    logic                accept;
    logic [CNT_W-1:0]    ones_sum;
    logic [CNT_W-1:0]    tog_sum;

    ota_sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d_i(cmp_in),
        .q_o(sample)
    );

    always_comb begin
        term      = en && (&phase_q);
        accept    = ack && valid_q;
        ones_sum  = acc_ones_q + CNT_W'(sample);
        tog_sum   = acc_tog_q + CNT_W'(sample ^ prev_q);

        // Dropping en discards the partial window; the wrap starts the next one gap-free.
        phase_d    = en ? phase_q + WIN_LOG2'(1) : '0;
        acc_ones_d = (en && !term) ? ones_sum : '0;
        acc_tog_d  = (en && !term) ? tog_sum : '0;

        ones_d    = term ? ones_sum : ones_q;
        tog_d     = term ? tog_sum : tog_q;
        valid_d   = term || (valid_q && !accept);

        overrun_d = overrun_q;
        if (term && valid_q && !ack) begin
            overrun_d = 1'b1;
        end else if (accept && !term) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q     <= 1'b0;
            phase_q    <= '0;
            acc_ones_q <= '0;
            acc_tog_q  <= '0;
            ones_q     <= '0;
            tog_q      <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            prev_q     <= sample;
            phase_q    <= phase_d;
            acc_ones_q <= acc_ones_d;
            acc_tog_q  <= acc_tog_d;
            ones_q     <= ones_d;
            tog_q      <= tog_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign ones_cnt = ones_q;
    assign tog_cnt  = tog_q;
    assign valid    = valid_q;
    assign overrun  = overrun_q;
    assign busy     = en;

endmodule

// File: tb/tb_ota_cmp_decimator.sv
// Bench for ota_cmp_decimator with a 16-cycle window and two-stage synchronizer;
// a history-based reference model predicts every output after every clock.
module tb_ota_cmp_decimator;

    localparam int WL  = 4;
    localparam int WIN = 16;
    localparam int CW  = WL + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          cmp_in;
    logic          ack;
    logic [CW-1:0] ones_cnt;
    logic [CW-1:0] tog_cnt;
    logic          valid;
    logic          overrun;
    logic          busy;

    always #5 clk = ~clk;

    ota_cmp_decimator #(
        .WIN_LOG2(WL),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .cmp_in(cmp_in),
        .ack(ack),
        .ones_cnt(ones_cnt),
        .tog_cnt(tog_cnt),
        .valid(valid),
        .overrun(overrun),
        .busy(busy)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: raw input history since reset, sampled-value history, and the open window.
    bit cmp_hist[$];
    bit samp_hist[$];
    int win_len, win_ones, win_tog;
    int exp_ones, exp_tog;
    bit exp_valid, exp_over;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        cmp_hist.delete();
        samp_hist.delete();
        win_len   = 0;
        win_ones  = 0;
        win_tog   = 0;
        exp_ones  = 0;
        exp_tog   = 0;
        exp_valid = 0;
        exp_over  = 0;
    endtask

    task automatic check_outputs(input bit e);
        check_val("ones_cnt", ones_cnt, exp_ones);
        check_val("tog_cnt", tog_cnt, exp_tog);
        check_val("valid", valid, exp_valid);
        check_val("overrun", overrun, exp_over);
        check_val("busy", busy, e);
    endtask

    // One clock cycle: drive inputs, predict, clock, compare.
    task automatic cycle(input bit e, input bit c, input bit a);
        bit s, p, done;
        int t;
        en     = e;
        cmp_in = c;
        ack    = a;
        t = cmp_hist.size();
        s = (t >= 2) ? cmp_hist[t-2] : 1'b0;
        p = (samp_hist.size() > 0) ? samp_hist[samp_hist.size()-1] : 1'b0;
        done = 0;
        if (e) begin
            win_ones += int'(s);
            win_tog  += int'(s != p);
            win_len++;
            done = (win_len == WIN);
        end else begin
            win_len  = 0;
            win_ones = 0;
            win_tog  = 0;
        end
        if (done) begin
            if (exp_valid && !a) exp_over = 1;
            exp_valid = 1;
            exp_ones  = win_ones;
            exp_tog   = win_tog;
            win_len   = 0;
            win_ones  = 0;
            win_tog   = 0;
        end else if (a && exp_valid) begin
            exp_valid = 0;
            exp_over  = 0;
        end
        cmp_hist.push_back(c);
        samp_hist.push_back(s);
        @(posedge clk);
        #1;
        check_outputs(e);
    endtask

    task automatic check_zero_outputs();
        check_val("rst_ones", ones_cnt, 0);
        check_val("rst_tog", tog_cnt, 0);
        check_val("rst_valid", valid, 0);
        check_val("rst_overrun", overrun, 0);
    endtask

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        cmp_in = 1'b0;
        ack    = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs();
        check_val("rst_busy", busy, 0);
        rst = 1'b0;

        // Constant 1: fill the synchronizer first so the window starts on the 0->1 edge.
        cycle(0, 1, 0);
        cycle(0, 1, 0);
        for (int i = 0; i < WIN; i++) cycle(1, 1, 0);
        check_val("c1_first_ones", ones_cnt, 16);
        check_val("c1_first_tog", tog_cnt, 1);
        check_val("c1_first_valid", valid, 1);
        for (int i = 0; i < WIN; i++) cycle(1, 1, i == 0);
        check_val("c1_ones", ones_cnt, 16);
        check_val("c1_tog", tog_cnt, 0);

        // Constant 0, acked once per window.
        for (int w = 0; w < 3; w++)
            for (int i = 0; i < WIN; i++) cycle(1, 0, i == 0);
        check_val("c0_ones", ones_cnt, 0);
        check_val("c0_tog", tog_cnt, 0);
        check_val("c0_valid", valid, 1);
        check_val("c0_overrun", overrun, 0);

        // Toggle every clock.
        for (int w = 0; w < 3; w++)
            for (int i = 0; i < WIN; i++) cycle(1, bit'(i % 2), i == 0);
        check_val("t1_ones", ones_cnt, 8);
        check_val("t1_tog", tog_cnt, 16);

        // Toggle every two clocks.
        for (int w = 0; w < 3; w++)
            for (int i = 0; i < WIN; i++) cycle(1, bit'((i / 2) % 2), i == 0);
        check_val("t2_ones", ones_cnt, 8);
        check_val("t2_tog", tog_cnt, 8);

        // Two unacked windows, then an ack coinciding with completion.
        for (int i = 0; i < WIN; i++) cycle(1, 1'($urandom % 2), i == 0);
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < WIN; i++) cycle(1, 1'($urandom % 2), 0);
        check_val("ovr_valid", valid, 1);
        check_val("ovr_overrun", overrun, 1);
        for (int i = 0; i < WIN; i++) cycle(1, 1'($urandom % 2), i == WIN - 1);
        check_val("ovr_ackdone_valid", valid, 1);
        check_val("ovr_ackdone_overrun", overrun, 1);
        cycle(1, 1'($urandom % 2), 1);
        check_val("ovr_cleared_valid", valid, 0);
        check_val("ovr_cleared_overrun", overrun, 0);
        for (int i = 1; i < WIN; i++) cycle(1, 1'($urandom % 2), 0);

        // en dropped at phase 9, then re-raised.
        for (int i = 0; i < 9; i++) cycle(1, 1'($urandom % 2), i == 0);
        for (int i = 0; i < 5; i++) cycle(0, 1'($urandom % 2), 0);
        check_val("endrop_valid", valid, 0);
        for (int i = 0; i < WIN - 1; i++) cycle(1, 1'($urandom % 2), 0);
        check_val("endrop_early_valid", valid, 0);
        cycle(1, 1'($urandom % 2), 0);
        check_val("endrop_late_valid", valid, 1);

        // Reset asserted at phase 7 of a window.
        for (int i = 0; i < 7; i++) cycle(1, 1'($urandom % 2), i == 0);
        rst = 1'b1;
        #1;
        check_zero_outputs();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < WIN - 1; i++) cycle(1, 1'($urandom % 2), 0);
        check_val("rstwin_early_valid", valid, 0);
        cycle(1, 1'($urandom % 2), 0);
        check_val("rstwin_late_valid", valid, 1);

        // Randomized traffic: occasional en drops, random acks, mixed input patterns.
        for (int i = 0; i < 800; i++) begin
            bit e, c, a;
            e = ($urandom % 25) != 0;
            case ((i / 64) % 3)
                0:       c = 1'($urandom % 2);
                1:       c = ($urandom % 8) != 0;
                default: c = 1'((i / (1 + (i / 192) % 3)) % 2);
            endcase
            a = ($urandom % 3) == 0;
            cycle(e, c, a);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
